// File: rtl/can_pkg.sv
// Shared types and defaults for the CAN bit-timing controller.
// Optional build macro: CAN_TRIPLE_SAMPLE_EN (2-of-3 majority sampling).
package can_pkg;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TSEG1 = 2'd1,
    ST_TSEG2 = 2'd2
  } can_bt_state_e;

  localparam int CAN_OVS_DEF   = 16;
  localparam int CAN_TSEG1_DEF = 11;
  localparam int CAN_TSEG2_DEF = 4;
  localparam int CAN_SJW_DEF   = 1;

  // Width of the per-segment TQ slot counter.
  localparam int CAN_CNT_W = 5;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/can_edge_det.sv
// Bus history for the bit-timing controller: previous-TQ RX value, falling-edge
// flag and sampled value (2-of-3 majority when CAN_TRIPLE_SAMPLE_EN is defined).
module can_edge_det
  import can_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic tq_tick,
  input  logic rx_in,
  output logic edge_fall,
  output logic sample_val
);

  logic rx_q;

`ifdef CAN_TRIPLE_SAMPLE_EN
  logic rx_q2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_q  <= 1'b1;
      rx_q2 <= 1'b1;
    end else if (tq_tick) begin
      rx_q  <= rx_in;
      rx_q2 <= rx_q;
    end
  end

  // The two previous ticks always end TSEG1 slots because TSEG1 is at least 3 TQ.
  assign sample_val = maj3(rx_in, rx_q, rx_q2);
`else
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_q <= 1'b1;
    end else if (tq_tick) begin
      rx_q <= rx_in;
    end
  end

  assign sample_val = rx_in;
`endif

  assign edge_fall = rx_q & ~rx_in;

endmodule

// File: rtl/can_bit_timing.sv
// CAN bit-timing controller: sequences SYNC/TSEG1/TSEG2 on TQ ticks, samples RX,
// launches TX and applies hard sync / SJW-limited resync. Macro: CAN_TRIPLE_SAMPLE_EN.
module can_bit_timing
  import can_pkg::*;
#(
  parameter int OVS_FACTOR = CAN_OVS_DEF,
  parameter int TSEG1      = CAN_TSEG1_DEF,
  parameter int TSEG2      = CAN_TSEG2_DEF,
  parameter int SJW        = CAN_SJW_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tq_tick,
  input  logic rx_in,
  input  logic tx_bit,
  input  logic hard_sync_en,
  output logic bit_start,
  output logic sample_point,
  output logic rx_bit,
  output logic tx_out,
  output logic bit_err
);

  if (OVS_FACTOR != 1 + TSEG1 + TSEG2) begin : g_chk_ovs
    $error("can_bit_timing: OVS_FACTOR must equal 1+TSEG1+TSEG2");
  end
  if (TSEG1 < 3 || TSEG1 > 15) begin : g_chk_tseg1
    $error("can_bit_timing: TSEG1 out of range 3..15");
  end
  if (TSEG2 < 2 || TSEG2 > 8) begin : g_chk_tseg2
    $error("can_bit_timing: TSEG2 out of range 2..8");
  end
  if (SJW < 1 || SJW > 4 || SJW > TSEG2) begin : g_chk_sjw
    $error("can_bit_timing: SJW must be 1..min(4,TSEG2)");
  end

  localparam logic [CAN_CNT_W-1:0] TSEG1_C = CAN_CNT_W'(TSEG1);
  localparam logic [CAN_CNT_W-1:0] TSEG2_C = CAN_CNT_W'(TSEG2);
  localparam logic [CAN_CNT_W-1:0] SJW_C   = CAN_CNT_W'(SJW);
  localparam logic [CAN_CNT_W-1:0] CNT_ONE = CAN_CNT_W'(1);

  can_bt_state_e        state, state_n;
  logic [CAN_CNT_W-1:0] cnt, cnt_n;
  logic [CAN_CNT_W-1:0] ext, ext_n;
  logic [CAN_CNT_W-1:0] shrink, shrink_n;
  logic                 resync_done, resync_done_n;
  logic                 tx_out_n, rx_bit_n;
  logic                 bit_start_n, sample_point_n, bit_err_n;
  logic                 start_ev, sample_ev, resync_ev;
  logic                 edge_fall, sample_val, resync_ok;

  can_edge_det u_edge_det (
    .clk        (clk),
    .rst_n      (rst_n),
    .tq_tick    (tq_tick),
    .rx_in      (rx_in),
    .edge_fall  (edge_fall),
    .sample_val (sample_val)
  );

  // Our own dominant bit would look like an edge, so resync only while sending recessive.
  assign resync_ok = edge_fall & tx_out & ~resync_done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_SYNC;
      cnt          <= '0;
      ext          <= '0;
      shrink       <= '0;
      resync_done  <= 1'b0;
      tx_out       <= 1'b1;
      rx_bit       <= 1'b1;
      bit_start    <= 1'b0;
      sample_point <= 1'b0;
      bit_err      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      ext          <= ext_n;
      shrink       <= shrink_n;
      resync_done  <= resync_done_n;
      tx_out       <= tx_out_n;
      rx_bit       <= rx_bit_n;
      bit_start    <= bit_start_n;
      sample_point <= sample_point_n;
      bit_err      <= bit_err_n;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ext_n     = ext;
    shrink_n  = shrink;
    start_ev  = 1'b0;
    sample_ev = 1'b0;
    resync_ev = 1'b0;
    if (tq_tick) begin
      if (hard_sync_en && edge_fall) begin
        // The ending TQ becomes SYNC; the next TQ is TSEG1 slot 0.
        state_n   = ST_TSEG1;
        cnt_n     = '0;
        ext_n     = '0;
        shrink_n  = '0;
        start_ev  = 1'b1;
        resync_ev = 1'b1;
      end else begin
        unique case (state)
          ST_SYNC: begin
            state_n = ST_TSEG1;
            cnt_n   = '0;
          end
          ST_TSEG1: begin
            if (resync_ok) begin
              ext_n     = (cnt < SJW_C) ? cnt + CNT_ONE : SJW_C;
              resync_ev = 1'b1;
            end
            if (cnt >= TSEG1_C + ext_n - CNT_ONE) begin
              state_n   = ST_TSEG2;
              cnt_n     = '0;
              sample_ev = 1'b1;
            end else begin
              cnt_n = cnt + CNT_ONE;
            end
          end
          ST_TSEG2: begin
            if (resync_ok && (TSEG2_C - cnt) <= SJW_C) begin
              state_n   = ST_TSEG1;
              cnt_n     = '0;
              ext_n     = '0;
              shrink_n  = '0;
              start_ev  = 1'b1;
              resync_ev = 1'b1;
            end else begin
              if (resync_ok) begin
                shrink_n  = SJW_C;
                resync_ev = 1'b1;
              end
              if (cnt >= TSEG2_C - shrink_n - CNT_ONE) begin
                state_n  = ST_SYNC;
                cnt_n    = '0;
                ext_n    = '0;
                shrink_n = '0;
                start_ev = 1'b1;
              end else begin
                cnt_n = cnt + CNT_ONE;
              end
            end
          end
          default: begin
            state_n = ST_SYNC;
            cnt_n   = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    tx_out_n       = start_ev ? tx_bit : tx_out;
    rx_bit_n       = sample_ev ? sample_val : rx_bit;
    bit_start_n    = start_ev;
    sample_point_n = sample_ev;
    bit_err_n      = sample_ev & (sample_val != tx_out);
    resync_done_n  = resync_done;
    if (resync_ev) begin
      resync_done_n = 1'b1;
    end else if (sample_ev) begin
      resync_done_n = 1'b0;
    end
  end

endmodule

// File: doc/can_bit_timing.md
# can_bit_timing

Bit-timing controller for the CAN harness. It consumes the time-quantum tick from `baud_gen` (`tick_16x`) and sequences each CAN bit through SYNC, TSEG1 and TSEG2. It samples the bus at the sample point and launches TX bits at bit start. It applies hard synchronisation and SJW-limited resynchronisation on recessive-to-dominant edges. It sits between `baud_gen` and the CAN MAC/frame FSM.

## Interface
- `OVS_FACTOR`, 16: time quanta (TQ) per nominal bit; must equal 1+TSEG1+TSEG2
- `TSEG1`, 11: TQs in the prop+phase1 segment, legal range 3..15
- `TSEG2`, 4: TQs in the phase2 segment, legal range 2..8
- `SJW`, 1: sync jump width in TQs, 1..min(4,TSEG2)
- `clk` in 1: system clock (64 MHz)
- `rst_n` in 1: synchronous, active-low reset
- `tq_tick` in 1: single-cycle TQ strobe from `baud_gen.tick_16x`; at most one per 2 clocks
- `rx_in` in 1: CAN RX, already synchronised upstream; 1 = recessive
- `tx_bit` in 1: next bit to transmit, from MAC
- `hard_sync_en` in 1: MAC permits hard sync (bus idle / awaiting SOF)
- `bit_start` out 1: one-cycle pulse when a bit enters SYNC; MAC updates `tx_bit` after it
- `sample_point` out 1: one-cycle pulse; `rx_bit` is valid the same cycle
- `rx_bit` out 1: sampled bus value
- `tx_out` out 1: CAN TX drive; 1 = recessive
- `bit_err` out 1: one-cycle pulse at `sample_point` when `rx_bit != tx_out`

## Operation
- Compile-time assertions check the `OVS_FACTOR` equality, the parameter ranges, and `SJW <= TSEG2`.
- FSM states: SYNC (1 TQ), TSEG1 (`TSEG1` + ext TQ), TSEG2 (`TSEG2` − shrink TQ). There is a 5-bit slot counter `cnt`, which clears on every state change.
- All state changes happen only on `tq_tick`.
- `rx_in` is captured on every `tq_tick` into `rx_q`.
- An edge is detected when `rx_q==1 && rx_in==0` on a tick. The edge belongs to the TQ ending at that tick.
- Edges are ignored for resync when `tx_out==0`, or when `resync_done` is set.
- `resync_done` sets on any resync and clears at `sample_point`.
- **Hard sync** (`hard_sync_en` && edge, in any state; overrides resync):
  - The ending TQ is treated as SYNC.
  - The next TQ is TSEG1 slot 0.
  - `bit_start` pulses on that tick and `tx_out` loads `tx_bit`.
  - `resync_done` is set.
- **Late edge** in TSEG1 slot i:
  - Phase error e = i+1.
  - TSEG1 is lengthened by min(e, SJW) TQs for this bit only.
- **Early edge** in TSEG2 slot j:
  - Phase error e = TSEG2−j.
  - If e ≤ SJW: the ending TQ becomes SYNC; `bit_start` pulses and the next TQ is TSEG1 slot 0.
  - Otherwise: TSEG2 ends after TSEG2−SJW slots in total.
- An edge in SYNC causes no action.
- `sample_point` fires on the tick that ends the last TSEG1 slot. The same tick loads `rx_bit` and evaluates `bit_err`.
- On the tick that ends TSEG2, the FSM enters SYNC, pulses `bit_start`, and loads `tx_out <= tx_bit`.

## Timing
- Reset values: state = SYNC, `cnt` = 0, `tx_out` = 1, `rx_bit` = 1, `rx_q` = 1, all pulses 0, `resync_done` = 0, ext/shrink = 0.
- All outputs are registered. Pulses assert in the clock cycle after the qualifying `tq_tick` edge and last exactly 1 cycle.
- Nominal bit = 16 TQ. `sample_point` comes 12 ticks after `bit_start` (default parameters).
- Reset mid-bit abandons the bit immediately. `tx_out` goes recessive on the next clock.
- A tick with no edge and `cnt` mid-segment only increments `cnt`.
- Simultaneous hard sync and early-edge conditions: hard sync wins.

## Configuration
- `CAN_TRIPLE_SAMPLE_EN` defined:
  - `rx_bit` is the 2-of-3 majority of `rx_in` at the ticks ending the last three TQs of TSEG1.
  - `bit_err` and `sample_point` timing are unchanged.
- Undefined: single sample at the tick ending the last TQ of TSEG1.

## Structure
- `can_pkg` holds:
  - the `can_bt_state_e` enum (SYNC, TSEG1, TSEG2)
  - the default TSEG1/TSEG2/SJW localparams
  - the TQ counter width constant (5)
- Optional sub-module `can_edge_det`: holds `rx_q`, produces the edge flag and, when `CAN_TRIPLE_SAMPLE_EN` is defined, the majority history.

## Test plan
- **Idle recessive:** `rx_in`=1, `tx_bit`=1, ticks every 4 clocks → `bit_start` every 16 ticks; `sample_point` 12 ticks after each; `rx_bit`=1; no `bit_err`.
- **Hard sync:** `hard_sync_en`=1, falling edge at TSEG1 slot 5 → `bit_start` on that tick; `sample_point` exactly 11 ticks later.
- **Late edge:** `tx_out`=1, falling edge in TSEG1 slot 2, SJW=1 → that bit lasts 17 TQ; `sample_point` 13 ticks after `bit_start`. A second edge before the sample point is ignored.
- **Early edge:** edge in TSEG2 slot 3 (e=1) → bit length 15 TQ with an immediate `bit_start`. Edge in slot 1 (e=3) → TSEG2 shortened to 3 TQ.
- **Bit error / masking:** `tx_bit`=0 with `rx_in` held 1 → `tx_out`=0 and `bit_err` pulses at `sample_point`. An edge while `tx_out`=0 causes no resync.
- **Reset mid-TSEG2:** `rst_n`=0 for one clock → all outputs at reset values next cycle; the bit restarts from SYNC.
